// File: rtl/cim_pkg.sv
// Shared constants for the CIM host sequencer: FSM state encoding, array row map and byte type.
package cim_pkg;

   localparam int BYTE_W = 8;
   typedef logic [BYTE_W-1:0] byte_t;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOAD_A    = 3'd1;
   localparam logic [2:0] S_LOAD_B    = 3'd2;
   localparam logic [2:0] S_COMPUTE   = 3'd3;
   localparam logic [2:0] S_WAIT_DONE = 3'd4;
   localparam logic [2:0] S_UNLOAD    = 3'd5;
   localparam logic [2:0] S_ERR       = 3'd6;

   localparam logic [2:0] ROW_VEC_A = 3'd0;
   localparam logic [2:0] ROW_VEC_B = 3'd1;
   localparam logic [2:0] ROW_PROD0 = 3'd2;

   // Column address of the last byte in a row, truncated to the 8-bit column bus.
   function automatic logic [7:0] col_last(input int ncols);
      return 8'(ncols - 1);
   endfunction

endpackage

// File: rtl/cim_out_skid.sv
// One-entry valid/ready output buffer fed by a READ_LAT-deep read-valid pipe from the CIM array.
module cim_out_skid
   import cim_pkg::*;
#(
   parameter int READ_LAT = 1
)
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  rd_issue,
   input  logic  rd_last,
   input  byte_t rd_data,
   input  logic  m_ready,
   output byte_t m_data,
   output logic  m_valid,
   output logic  m_last,
   output logic  can_issue
);

   logic [READ_LAT-1:0] vld_pipe_reg;
   logic [READ_LAT-1:0] last_pipe_reg;
   logic                buf_valid_reg;
   logic                buf_last_reg;
   byte_t               buf_data_reg;
   logic                rd_arrive;
   logic                in_flight;

   assign rd_arrive = vld_pipe_reg[READ_LAT-1];
   assign in_flight = |vld_pipe_reg;
   // At most one byte lives in pipe+buffer, so a new read only goes out once the buffer is leaving.
   assign can_issue = !in_flight && (!buf_valid_reg || m_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_reg  <= '0;
         last_pipe_reg <= '0;
      end else begin
         vld_pipe_reg[0]  <= rd_issue;
         last_pipe_reg[0] <= rd_issue & rd_last;
         for (int i = 1; i < READ_LAT; i++) begin
            vld_pipe_reg[i]  <= vld_pipe_reg[i-1];
            last_pipe_reg[i] <= last_pipe_reg[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid_reg <= 1'b0;
         buf_last_reg  <= 1'b0;
         buf_data_reg  <= '0;
      end else if (rd_arrive) begin
         buf_valid_reg <= 1'b1;
         buf_last_reg  <= last_pipe_reg[READ_LAT-1];
         buf_data_reg  <= rd_data;
      end else if (buf_valid_reg && m_ready) begin
         buf_valid_reg <= 1'b0;
         buf_last_reg  <= 1'b0;
      end
   end

   assign m_data  = buf_data_reg;
   assign m_valid = buf_valid_reg;
   assign m_last  = buf_valid_reg & buf_last_reg;

endmodule

// File: rtl/cim_host_seq.sv
// Host-side sequencer for the CIM array: load rows A/B, pulse En, await DONE, stream product rows out.
// Optional build macro CIM_HOST_CSUM_EN adds XOR checksums of loaded and unloaded bytes.
module cim_host_seq
   import cim_pkg::*;
#(
   parameter int NCOLS     = 32,
   parameter int NOUT_ROWS = 2,
   parameter int READ_LAT  = 1,
   parameter int TIMEOUT   = 64
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [7:0]  m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_last,
   output logic        busy,
   output logic        done,
   output logic        err_timeout,
   output logic [2:0]  mem_row_addr,
   output logic [7:0]  mem_col_addr,
   output logic [7:0]  mem_data_in,
   output logic        mem_write,
   output logic        mem_read,
   output logic        mem_en,
   input  logic [7:0]  mem_data_out,
   input  logic        mem_done
`ifdef CIM_HOST_CSUM_EN
   ,
   output logic [7:0]  csum_in,
   output logic [7:0]  csum_out
`endif
);

   localparam logic [7:0] COL_LAST = col_last(NCOLS);
   localparam logic [2:0] ROW_LAST = 3'(int'(ROW_PROD0) + NOUT_ROWS - 1);
   localparam int         WCNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(TIMEOUT);

   logic [2:0]        state_reg,    state_next;
   logic [7:0]        col_reg,      col_next;
   logic [2:0]        row_reg,      row_next;
   logic [WCNT_W-1:0] wait_cnt_reg, wait_cnt_next;
   logic              rd_all_reg,   rd_all_next;
   logic              err_reg,      err_next;
   logic              done_reg,     done_next;

   logic load_hs;
   logic out_hs;
   logic rd_issue;
   logic rd_last;
   logic can_issue;
   logic start_acc;

   assign s_ready   = (state_reg == S_LOAD_A) || (state_reg == S_LOAD_B);
   assign load_hs   = s_valid && s_ready;
   assign start_acc = (state_reg == S_IDLE) && start;
   assign out_hs    = m_valid && m_ready;
   assign rd_issue  = (state_reg == S_UNLOAD) && !rd_all_reg && can_issue;
   assign rd_last   = (row_reg == ROW_LAST) && (col_reg == COL_LAST);

   // Array strobes are combinational from registered address so a write lands in its handshake cycle.
   assign mem_write    = load_hs;
   assign mem_data_in  = load_hs ? s_data : 8'h00;
   assign mem_row_addr = row_reg;
   assign mem_col_addr = col_reg;
   assign mem_read     = rd_issue;
   assign mem_en       = (state_reg == S_COMPUTE);
   assign busy         = (state_reg != S_IDLE);
   assign done         = done_reg;
   assign err_timeout  = err_reg;

   cim_out_skid #(
      .READ_LAT (READ_LAT)
   ) u_out_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_issue  (rd_issue),
      .rd_last   (rd_last),
      .rd_data   (mem_data_out),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_last    (m_last),
      .can_issue (can_issue)
   );

   always_comb begin
      state_next    = state_reg;
      col_next      = col_reg;
      row_next      = row_reg;
      wait_cnt_next = wait_cnt_reg;
      rd_all_next   = rd_all_reg;
      err_next      = err_reg;
      done_next     = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_LOAD_A;
               col_next   = 8'd0;
               row_next   = ROW_VEC_A;
               err_next   = 1'b0;
            end
         end
         S_LOAD_A, S_LOAD_B: begin
            if (load_hs) begin
               if (col_reg == COL_LAST) begin
                  col_next = 8'd0;
                  if (state_reg == S_LOAD_A) begin
                     state_next = S_LOAD_B;
                     row_next   = ROW_VEC_B;
                  end else begin
                     state_next = S_COMPUTE;
                  end
               end else begin
                  col_next = col_reg + 8'd1;
               end
            end
         end
         S_COMPUTE: begin
            state_next    = S_WAIT_DONE;
            wait_cnt_next = '0;
         end
         S_WAIT_DONE: begin
            // A DONE arriving on the timeout cycle itself still counts as success.
            if (mem_done) begin
               state_next  = S_UNLOAD;
               row_next    = ROW_PROD0;
               col_next    = 8'd0;
               rd_all_next = 1'b0;
            end else if (wait_cnt_reg == WAIT_MAX) begin
               state_next = S_ERR;
               err_next   = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt_reg + 1'b1;
            end
         end
         S_UNLOAD: begin
            if (rd_issue) begin
               if (col_reg == COL_LAST) begin
                  col_next = 8'd0;
                  if (row_reg == ROW_LAST) begin
                     rd_all_next = 1'b1;
                  end else begin
                     row_next = row_reg + 3'd1;
                  end
               end else begin
                  col_next = col_reg + 8'd1;
               end
            end
            if (out_hs && m_last) begin
               state_next = S_IDLE;
               row_next   = ROW_VEC_A;
               col_next   = 8'd0;
               done_next  = 1'b1;
            end
         end
         S_ERR: begin
            state_next = S_IDLE;
            row_next   = ROW_VEC_A;
            col_next   = 8'd0;
         end
         default: begin
            state_next = S_IDLE;
            row_next   = ROW_VEC_A;
            col_next   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         col_reg      <= 8'd0;
         row_reg      <= 3'd0;
         wait_cnt_reg <= '0;
         rd_all_reg   <= 1'b0;
         err_reg      <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         col_reg      <= col_next;
         row_reg      <= row_next;
         wait_cnt_reg <= wait_cnt_next;
         rd_all_reg   <= rd_all_next;
         err_reg      <= err_next;
         done_reg     <= done_next;
      end
   end

`ifdef CIM_HOST_CSUM_EN
   logic [7:0] csum_in_reg;
   logic [7:0] csum_out_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_in_reg  <= 8'h00;
         csum_out_reg <= 8'h00;
      end else if (start_acc) begin
         csum_in_reg  <= 8'h00;
         csum_out_reg <= 8'h00;
      end else begin
         if (load_hs) begin
            csum_in_reg <= csum_in_reg ^ s_data;
         end
         if (out_hs) begin
            csum_out_reg <= csum_out_reg ^ m_data;
         end
      end
   end

   assign csum_in  = csum_in_reg;
   assign csum_out = csum_out_reg;
`else
   logic unused_start_acc;
   assign unused_start_acc = start_acc;
`endif

endmodule
